// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges the never-stalled ALU pipe and the buffered LSU onto the
// single register-file write port. Optional forwarding taps are enabled by `define WB_FWD_EN.
module wb_write_arbiter #(
    parameter int XLEN      = 32,
    parameter int LSU_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic            lsu_pending,
    input  logic [4:0]      fwd_ra1,
    input  logic [4:0]      fwd_ra2,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2
);

    localparam int PW = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [4:0]           ent_rd_q   [LSU_DEPTH];
    logic [XLEN-1:0]      ent_data_q [LSU_DEPTH];
    logic [LSU_DEPTH-1:0] ent_vld_q, ent_vld_d;
    logic [PW-1:0]        rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic                 rf_we_q, rf_we_d;
    logic [4:0]           rf_wa_q, rf_wa_d;
    logic [XLEN-1:0]      rf_wd_q, rf_wd_d;

    logic                 alu_sel, fifo_empty, xfer, lsu_drop;
    logic                 pop, push, bypass;

    assign alu_sel     = alu_valid && (alu_rd != 5'd0);
    assign fifo_empty  = (count_q == '0);
    // Ready looks only at the registered count: a full FIFO never pops through.
    assign lsu_ready   = (count_q < CW'(LSU_DEPTH));
    assign xfer        = lsu_valid && lsu_ready;
    assign lsu_drop    = (lsu_rd == 5'd0) || (alu_sel && (lsu_rd == alu_rd));
    assign lsu_pending = !fifo_empty;

    always_comb begin
        ent_vld_d = ent_vld_q;
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        count_d   = count_q;
        rf_we_d   = 1'b0;
        rf_wa_d   = rf_wa_q;
        rf_wd_d   = rf_wd_q;
        pop       = 1'b0;
        bypass    = 1'b0;

        if (alu_sel) begin
            rf_we_d = 1'b1;
            rf_wa_d = alu_rd;
            rf_wd_d = alu_data;
            // Queued LSU results are older, so a newer ALU write to the same rd kills them.
            for (int i = 0; i < LSU_DEPTH; i++) begin
                if (ent_rd_q[i] == alu_rd) begin
                    ent_vld_d[i] = 1'b0;
                end
            end
        end else if (!fifo_empty) begin
            pop = 1'b1;
            if (ent_vld_q[rptr_q]) begin
                rf_we_d = 1'b1;
                rf_wa_d = ent_rd_q[rptr_q];
                rf_wd_d = ent_data_q[rptr_q];
            end
            ent_vld_d[rptr_q] = 1'b0;
            rptr_d            = rptr_q + PW'(1);
        end else if (xfer && !lsu_drop) begin
            bypass  = 1'b1;
            rf_we_d = 1'b1;
            rf_wa_d = lsu_rd;
            rf_wd_d = lsu_data;
        end

        push = xfer && !lsu_drop && !bypass;
        if (push) begin
            ent_vld_d[wptr_q] = 1'b1;
            wptr_d            = wptr_q + PW'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld_q <= '0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_wa_q   <= '0;
            rf_wd_q   <= '0;
        end else begin
            ent_vld_q <= ent_vld_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            rf_we_q   <= rf_we_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
        end
    end

    // Payload storage needs no reset; entry valid bits qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd_q[wptr_q]   <= lsu_rd;
            ent_data_q[wptr_q] <= lsu_data;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wa = rf_wa_q;
    assign rf_wd = rf_wd_q;

`ifdef WB_FWD_EN
    assign fwd_hit1  = rf_we_q && (rf_wa_q == fwd_ra1) && (fwd_ra1 != 5'd0);
    assign fwd_hit2  = rf_we_q && (rf_wa_q == fwd_ra2) && (fwd_ra2 != 5'd0);
    assign fwd_data1 = rf_wd_q;
    assign fwd_data2 = rf_wd_q;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_ra1, fwd_ra2};
    assign fwd_hit1   = 1'b0;
    assign fwd_hit2   = 1'b0;
    assign fwd_data1  = '0;
    assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the writeback rules.
module tb_wb_write_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid, lsu_valid, lsu_ready;
    logic [4:0]      alu_rd, lsu_rd, rf_wa, fwd_ra1, fwd_ra2;
    logic [XLEN-1:0] alu_data, lsu_data, rf_wd, fwd_data1, fwd_data2;
    logic            rf_we, lsu_pending, fwd_hit1, fwd_hit2;

    always #5 clk = ~clk;

    wb_write_arbiter #(.XLEN(XLEN), .LSU_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .lsu_pending(lsu_pending),
        .fwd_ra1(fwd_ra1), .fwd_ra2(fwd_ra2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          v;
    } ent_t;

    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit          last_xfer;
    logic [4:0]  wlog[$];
    logic [31:0] last4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
    endtask

    task automatic model_step();
        bit   ready, xfer, alu_w, byp;
        ent_t e;
        ready = (mq.size() < DEPTH);
        xfer  = lsu_valid && ready;
        alu_w = alu_valid && (alu_rd != 0);
        byp   = 0;
        if (alu_w) begin
            foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].v = 0;
            m_we = 1'b1; m_wa = alu_rd; m_wd = alu_data;
        end else if (mq.size() != 0) begin
            e = mq.pop_front();
            m_we = e.v;
            if (e.v) begin m_wa = e.rd; m_wd = e.data; end
        end else if (xfer && lsu_rd != 0) begin
            byp = 1;
            m_we = 1'b1; m_wa = lsu_rd; m_wd = lsu_data;
        end else begin
            m_we = 1'b0;
        end
        if (xfer && lsu_rd != 0 && !byp && !(alu_w && lsu_rd == alu_rd))
            mq.push_back('{rd: lsu_rd, data: lsu_data, v: 1'b1});
    endtask

    task automatic chk_fwd();
`ifdef WB_FWD_EN
        chk("fwd_hit1", 32'(fwd_hit1), 32'(m_we && m_wa == fwd_ra1 && fwd_ra1 != 0));
        chk("fwd_hit2", 32'(fwd_hit2), 32'(m_we && m_wa == fwd_ra2 && fwd_ra2 != 0));
        chk("fwd_data1", fwd_data1, m_wd);
        chk("fwd_data2", fwd_data2, m_wd);
`else
        chk("fwd_hit1", 32'(fwd_hit1), 32'd0);
        chk("fwd_hit2", 32'(fwd_hit2), 32'd0);
        chk("fwd_data1", fwd_data1, 32'd0);
        chk("fwd_data2", fwd_data2, 32'd0);
`endif
    endtask

    // One clock: check pre-edge outputs, advance model, check registered outputs after the edge.
    task automatic cyc();
        #1;
        chk("lsu_ready", 32'(lsu_ready), 32'(mq.size() < DEPTH));
        chk("lsu_pending", 32'(lsu_pending), 32'(mq.size() != 0));
        chk_fwd();
        last_xfer = lsu_valid && lsu_ready;
        model_step();
        @(posedge clk);
        #1;
        chk("rf_we", 32'(rf_we), 32'(m_we));
        chk("rf_wa", 32'(rf_wa), 32'(m_wa));
        chk("rf_wd", rf_wd, m_wd);
        if (rf_we) begin
            wlog.push_back(rf_wa);
            if (rf_wa == 5'd4) last4 = rf_wd;
        end
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        fwd_ra1 = 0; fwd_ra2 = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [4:0] t2_rd[3];
    logic [4:0] t2_exp[8];
    int         idx;

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_rf_wa", 32'(rf_wa), 32'd0);
        chk("reset_rf_wd", rf_wd, 32'd0);
        chk("reset_ready", 32'(lsu_ready), 32'd1);
        chk("reset_pending", 32'(lsu_pending), 32'd0);
        do_reset();

        // LSU bypass into an empty FIFO
        lsu_valid = 1; lsu_rd = 5; lsu_data = 32'hAAAA0001;
        cyc();
        chk("byp_we", 32'(rf_we), 32'd1);
        chk("byp_wa", 32'(rf_wa), 32'd5);
        chk("byp_wd", rf_wd, 32'hAAAA0001);
        chk("byp_pending", 32'(lsu_pending), 32'd0);
        idle();
        cyc();

        // ALU traffic fills the FIFO, then the queue drains in order
        t2_rd  = '{5'd7, 5'd8, 5'd9};
        t2_exp = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd7, 5'd8, 5'd9};
        wlog.delete();
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            alu_valid = (c < 5); alu_rd = 3; alu_data = 32'(c);
            lsu_valid = (idx < 3);
            lsu_rd    = (idx < 3) ? t2_rd[idx] : 5'd0;
            lsu_data  = 32'h100 + 32'(idx);
            if (c == 2) begin
                #1;
                chk("full_ready", 32'(lsu_ready), 32'd0);
            end
            cyc();
            if (last_xfer) idx++;
        end
        idle();
        chk("order_len", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < wlog.size()) chk($sformatf("order_%0d", i), 32'(wlog[i]), 32'(t2_exp[i]));
        cyc();

        // WAW kill: stale queued x4 must never reach the register file
        last4 = 32'hDEAD;
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h11;
        cyc();
        alu_valid = 1; alu_rd = 4; alu_data = 32'h22;
        lsu_valid = 0;
        cyc();
        idle();
        cyc();
        chk("waw_stale_pop_we", 32'(rf_we), 32'd0);
        cyc();
        chk("waw_final_x4", last4, 32'h22);
        chk("waw_pending", 32'(lsu_pending), 32'd0);

        // x0 destinations never write and never occupy the FIFO
        for (int c = 0; c < 4; c++) begin
            alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
            lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hEEEE;
            cyc();
            chk("x0_we", 32'(rf_we), 32'd0);
            chk("x0_ready", 32'(lsu_ready), 32'd1);
            chk("x0_pending", 32'(lsu_pending), 32'd0);
        end
        idle();

        // Reset asserted mid-drain with two entries queued
        for (int c = 0; c < 3; c++) begin
            alu_valid = 1; alu_rd = 3; alu_data = 32'h50 + 32'(c);
            lsu_valid = (c < 2); lsu_rd = 5'(10 + c); lsu_data = 32'h60 + 32'(c);
            cyc();
        end
        chk("pre_rst_pending", 32'(lsu_pending), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(rf_we), 32'd0);
        chk("mid_rst_pending", 32'(lsu_pending), 32'd0);
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(lsu_ready), 32'd1);
        chk("post_rst_pending", 32'(lsu_pending), 32'd0);
        cyc();
        chk("post_rst_we", 32'(rf_we), 32'd0);

        // Forwarding taps on a staged write
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        cyc();
        idle();
        fwd_ra1 = 5;
        #1;
`ifdef WB_FWD_EN
        chk("fwd5_hit", 32'(fwd_hit1), 32'd1);
        chk("fwd5_data", fwd_data1, 32'h1234);
`else
        chk("fwd5_hit", 32'(fwd_hit1), 32'd0);
        chk("fwd5_data", fwd_data1, 32'd0);
`endif
        fwd_ra1 = 0;
        #1;
        chk("fwd0_hit", 32'(fwd_hit1), 32'd0);
        cyc();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            alu_valid = ($urandom_range(0, 99) < 40);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            lsu_valid = ($urandom_range(0, 99) < 60);
            lsu_rd    = 5'($urandom_range(0, 7));
            lsu_data  = $urandom;
            fwd_ra1   = 5'($urandom_range(0, 7));
            fwd_ra2   = 5'($urandom_range(0, 7));
            cyc();
        end
        idle();
        repeat (4) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
